// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
package div_arbiter_pkg;

  localparam int N_DEF    = 4;
  localparam int DEC_DEF  = 4;
  localparam int NREQ_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DZ  = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    logic [PW-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates NREQ requesters onto one shared divider, one job in flight,
// with divide-by-zero bypass and a divider watchdog.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DEC  = DEC_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int TMO  = N + DEC + 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] dividend_in,
  input  logic [NREQ*N-1:0] divisor_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_q,
  output logic [1:0]        rsp_err,
  output logic              busy,
  output logic              div_sen1,
  output logic              div_sen2,
  output logic [N-1:0]      div_dividend,
  output logic [N-1:0]      div_divisor,
  input  logic [N-1:0]      div_q,
  input  logic              div_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  state_e          st_q, st_d;
  logic [PW-1:0]   ptr_q, ptr_d, own_q, own_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    dvd_q, dvd_d, dvs_q, dvs_d, res_q, res_d, rq_q, rq_d;
  logic [1:0]      err_q, err_d, rerr_q, rerr_d;
  logic [NREQ-1:0] rvld_q, rvld_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic            gany, grant;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  // Grant is combinational so ack lands in the same IDLE cycle as the request.
  assign grant    = reset_n && (st_q == S_IDLE) && gany;
  assign ack      = grant ? gnt : '0;
  assign busy     = (st_q != S_IDLE);
  assign div_sen1 = (st_q == S_START);
  assign div_sen2 = (st_q == S_LOAD);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign rsp_valid    = rvld_q;
  assign rsp_q        = rq_q;
  assign rsp_err      = rerr_q;

  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    own_d  = own_q;
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    res_d  = res_q;
    err_d  = err_q;
    rvld_d = '0;
    rq_d   = '0;
    rerr_d = '0;
    case (st_q)
      S_IDLE: if (grant) begin
        ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        own_d = gidx;
        dvd_d = dividend_in[int'(gidx)*N +: N];
        dvs_d = divisor_in[int'(gidx)*N +: N];
        if (dvs_d == '0) begin
          res_d = '1;
          err_d = ERR_DZ;
          st_d  = S_RESP;
        end else begin
          st_d  = S_START;
        end
      end
      S_START: st_d = S_LOAD;
      S_LOAD: begin
        cnt_d = '0;
        st_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done) begin
          res_d = div_q;
          err_d = ERR_OK;
          st_d  = S_RESP;
        end else if (cnt_q + 1'b1 == CW'(TMO)) begin
          res_d = '1;
          err_d = ERR_TMO;
          st_d  = S_RESP;
        end
      end
      // Response is registered out, so it appears the cycle after RESP.
      S_RESP: begin
        rvld_d[own_q] = 1'b1;
        rq_d          = res_q;
        rerr_d        = err_q;
        st_d          = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q   <= S_IDLE;
      ptr_q  <= '0;
      own_q  <= '0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      err_q  <= '0;
      rvld_q <= '0;
      rq_q   <= '0;
      rerr_q <= '0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      own_q  <= own_d;
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      res_q  <= res_d;
      err_q  <= err_d;
      rvld_q <= rvld_d;
      rq_q   <= rq_d;
      rerr_q <= rerr_d;
    end
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- N, 4, operand/quotient width.
- DEC, 4, fractional quotient bits produced by the shared divider.
- NREQ, 4, number of requesters.
- TMO, N+DEC+8, cycles allowed from divider start to done.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- req  in  NREQ  per-requester request level.
- dividend_in  in  NREQ*N  packed operands, requester i at bits [i*N +: N].
- divisor_in  in  NREQ*N  packed operands, same packing.
- ack  out  NREQ  one-hot, one-cycle pulse: request accepted, operands captured.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: response for requester i.
- rsp_q  out  N  quotient, valid only with rsp_valid.
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout; valid only with rsp_valid.
- busy  out  1  high in any state other than IDLE.
- div_sen1  out  1  divider arm strobe.
- div_sen2  out  1  divider start strobe.
- div_dividend  out  N  latched dividend to the divider.
- div_divisor  out  N  latched divisor to the divider.
- div_q  in  N  divider quotient.
- div_done  in  1  divider completion pulse, one cycle.

Function
REQ-003 FSM states SHALL be IDLE, START, LOAD, WAIT, RESP; exactly one job is in flight at a time.
REQ-004 Arbitration SHALL be round-robin in IDLE only. The pointer SHALL start at requester 0; after each grant it SHALL advance to the granted index+1, mod NREQ. Search SHALL begin at the pointer.
REQ-005 Grant in IDLE (any req high):
- ack[g] SHALL pulse in that same cycle.
- Operands of g SHALL be latched into div_dividend/div_divisor.
- g SHALL be stored as the job owner.
- Next state SHALL be RESP if the latched divisor is zero, else START.
REQ-006 Requester contract: hold req and operands stable until ack. Deassert req for at least the ack cycle; re-asserting req afterwards queues a new job.
REQ-007 Divider sequencing:
- START: div_sen1=1 for exactly one cycle, then LOAD.
- LOAD: div_sen2=1 for exactly one cycle, then WAIT.
- div_dividend/div_divisor SHALL stay stable from grant until leaving WAIT.
REQ-008 WAIT exit conditions:
- If div_done=1: capture div_q, err=00, go to RESP.
- Else if the wait counter (cleared in LOAD, +1 per WAIT cycle) reaches TMO: q=all-ones, err=10, go to RESP.
REQ-009 Divide-by-zero SHALL give q=all-ones, err=01 and SHALL NOT assert div_sen1/div_sen2.
REQ-010 RESP SHALL pulse rsp_valid[owner] for one cycle with rsp_q/rsp_err, then return to IDLE. Earliest next grant is the cycle after RESP.
REQ-011 Normal-job latency SHALL be: rsp_valid exactly 2 cycles after div_done is seen. For a divider with an N+DEC+2 cycle run this totals N+DEC+5 cycles from ack.
REQ-012 div_done while not in WAIT SHALL be ignored. A late done after a timeout SHALL NOT produce a second response.
REQ-013 Outside their response cycle, rsp_q and rsp_err SHALL hold 0 and rsp_valid SHALL be 0.
REQ-014 Requests arriving while busy SHALL wait. ack SHALL never pulse outside IDLE.

Reset
REQ-015 When reset_n=0 at a clock edge:
- State SHALL go to IDLE and the pointer to 0.
- ack, rsp_valid, rsp_q, rsp_err, busy, div_sen1, div_sen2, div_dividend, div_divisor and the wait counter SHALL all be 0.
REQ-016 Reset mid-job SHALL abandon the job with no rsp_valid. The divider SHALL be re-armed only by the next grant.

Structure
REQ-017 Package div_arbiter_pkg SHALL hold the state enum, the rsp_err code constants and the default parameter values.
REQ-018 Round-robin selection SHALL be one sub-module, rr_pick: combinational, req vector + pointer in, one-hot grant + index out. All state stays in div_arbiter.

Verification
REQ-019 Single job: req[0], 12/3 (N=8, DEC=0), divider model done after 10 cycles -> ack[0], sen1 and sen2 one cycle each, rsp_valid[0] with q=4, err=00.
REQ-020 Fairness: req=1111 held, operands re-presented after each ack -> ack order 0,1,2,3,0, never two consecutive grants to one requester while others wait.
REQ-021 Divide-by-zero: req[2], divisor 0 -> no sen1/sen2, rsp_valid[2] two cycles after ack, q=all-ones, err=01.
REQ-022 Timeout: divider model never asserts done -> rsp_err=10 exactly TMO WAIT cycles after LOAD; an injected late div_done yields no extra rsp_valid.
REQ-023 Reset mid-WAIT: reset_n=0 for one cycle -> all outputs 0, no rsp_valid, a fresh req[1] then gets ack[1] (pointer restarted at 0).
REQ-024 Back-to-back: req[3] asserted during RESP -> ack[3] in the first IDLE cycle, not earlier.
